// File: rtl/alu_pkg.sv
// Shared ALU types, command encodings and the combinational result function.
// Flag support in the stage is selected with the ALU_EXEC_FLAGS_EN macro.
package alu;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_ADD = 3'b001,
    CMD_SUB = 3'b010,
    CMD_AND = 3'b011,
    CMD_OR  = 3'b100,
    CMD_XOR = 3'b101
  } alu_cmd_e;

  typedef struct packed {
    alu_cmd_e              cmd;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } alu_task_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  carry;
  } alu_result_t;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

  // Bit DATA_WIDTH of the widened subtraction is the borrow, i.e. a < b unsigned.
  function automatic alu_result_t alu_calc(input alu_task_t t);
    logic [DATA_WIDTH:0] wide;
    alu_result_t         r;
    wide = '0;
    case (t.cmd)
      CMD_ADD: wide = {1'b0, t.a} + {1'b0, t.b};
      CMD_SUB: wide = {1'b0, t.a} - {1'b0, t.b};
      CMD_AND: wide = {1'b0, t.a & t.b};
      CMD_OR:  wide = {1'b0, t.a | t.b};
      CMD_XOR: wide = {1'b0, t.a ^ t.b};
      default: wide = '0;
    endcase
    r.result = wide[DATA_WIDTH-1:0];
    r.carry  = wide[DATA_WIDTH];
    r.zero   = (wide[DATA_WIDTH-1:0] == '0);
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu_calc_result(input alu_task_t t);
    alu_result_t r;
    r = alu_calc(t);
    return r.result;
  endfunction

endpackage

// File: rtl/alu_exec_skid.sv
// Generic 2-entry valid/ready buffer (main + skid slot) with a registered ready.
// Outputs come straight from the main register, so they never depend on out_ready_i.
module alu_exec_skid
  import alu::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = (state_q != SKID_EMPTY) & out_ready_i;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d  = SKID_ONE;
          m_data_d = in_data_i;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          m_data_d = in_data_i;
        end else if (in_fire) begin
          state_d  = SKID_TWO;
          s_data_d = in_data_i;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_fire) begin
          state_d  = SKID_ONE;
          m_data_d = s_data_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Ready is precomputed from the next state so it can leave a flop.
    in_ready_d = (state_d != SKID_TWO);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= SKID_EMPTY;
      m_data_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = m_data_q;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: alu_calc feeding a 2-entry skid buffer.
// Define ALU_EXEC_FLAGS_EN to carry zero/carry flags; otherwise those outputs are tied low.
module alu_exec_stage
  import alu::*;
#(
  parameter int DATA_WIDTH = alu::DATA_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  input  logic [$bits(alu_task_t)-1:0]  in_task_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_result_o,
  output logic                          out_zero_o,
  output logic                          out_carry_o,
  input  logic                          out_ready_i
);

  alu_task_t in_task;
  assign in_task = alu_task_t'(in_task_i);

`ifdef ALU_EXEC_FLAGS_EN
  alu_result_t calc;
  alu_result_t out_word;

  assign calc = alu_calc(in_task);

  alu_exec_skid #(
    .WIDTH($bits(alu_result_t))
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (calc),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_word),
    .out_ready_i (out_ready_i)
  );

  assign out_result_o = out_word.result;
  assign out_zero_o   = out_word.zero;
  assign out_carry_o  = out_word.carry;
`else
  logic [DATA_WIDTH-1:0] calc_result;

  assign calc_result = alu_calc_result(in_task);

  alu_exec_skid #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (calc_result),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_result_o),
    .out_ready_i (out_ready_i)
  );

  assign out_zero_o  = 1'b0;
  assign out_carry_o = 1'b0;
`endif

endmodule
